// File: rtl/tamper_pkg.sv
// Shared types and constants for the tamper monitor and response sequencer.
package tamper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_ZEROIZE = 2'd2,
        ST_HALT    = 2'd3
    } tamper_state_t;

    localparam logic TAMPER_INACTIVE_N = 1'b1;

endpackage

// File: rtl/tamper_debounce.sv
// Per-source debounce: a flag is accepted once on the sample that reaches DEBOUNCE
// consecutive highs, and cannot be accepted again until it has returned low.
module tamper_debounce
    import tamper_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic FLAG_IN,
    output logic ACCEPT
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [CW-1:0] cnt;

    // Counter parks at DEBOUNCE while the flag stays high, which blocks re-acceptance.
    assign ACCEPT = FLAG_IN && (cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (!FLAG_IN) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tamper_response_ctrl.sv
// Tamper monitor and response sequencer driving the TAMPER macro's active-low
// lockdown, I/O-disable and zeroize inputs from debounced, masked sticky status.
//
// state   | meaning
// IDLE    | no sticky status, all responses inactive
// LOCKED  | sticky status held, lock/IO outputs follow masks
// ZEROIZE | ZEROIZE_N low for ZEROIZE_HOLD cycles, lock/IO forced low
// HALT    | terminal; lock/IO low until reset
module tamper_response_ctrl
    import tamper_pkg::*;
#(
    parameter int NUM_SRC      = 8,
    parameter int DEBOUNCE     = 4,
    parameter int CNT_W        = 8,
    parameter int ZEROIZE_HOLD = 16
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [NUM_SRC-1:0] FLAG_IN,
    input  logic [NUM_SRC-1:0] LOCK_MASK,
    input  logic [NUM_SRC-1:0] IO_MASK,
    input  logic [NUM_SRC-1:0] ZERO_MASK,
    input  logic [3:0]         DETECT_CATEGORY,
    input  logic               TAMPER_CHANGE_STROBE,
    input  logic               CLEAR,
    output logic               LOCKDOWN_ALL_N,
    output logic               DISABLE_ALL_IOS_N,
    output logic               ZEROIZE_N,
    output logic [NUM_SRC-1:0] STATUS,
    output logic [3:0]         LAST_CATEGORY,
    output logic [CNT_W-1:0]   EVENT_COUNT,
    output logic               IRQ,
    output logic [1:0]         STATE
);

    localparam int TW = (ZEROIZE_HOLD > 1) ? $clog2(ZEROIZE_HOLD) : 1;
    localparam logic [TW-1:0] HOLD_LOAD = TW'(ZEROIZE_HOLD - 1);

    tamper_state_t      state;
    tamper_state_t      state_nxt;
    logic [NUM_SRC-1:0] accept;
    logic               any_accept;
    logic [NUM_SRC-1:0] status_q;
    logic [NUM_SRC-1:0] status_nxt;
    logic [CNT_W-1:0]   count_q;
    logic [TW-1:0]      hold_tmr;
    logic               irq_q;
    logic [3:0]         category_q;
    logic               lock_n_d;
    logic               io_n_d;
    logic               zero_n_d;
    logic               lock_n_q;
    logic               io_n_q;
    logic               zero_n_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        tamper_debounce #(
            .DEBOUNCE (DEBOUNCE)
        ) u_debounce (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .FLAG_IN (FLAG_IN[i]),
            .ACCEPT  (accept[i])
        );
    end

    assign any_accept = |accept;

    // A same-cycle acceptance survives CLEAR; only the older bits are dropped.
    always_comb begin
        status_nxt = status_q | accept;
        if (CLEAR && (state == ST_IDLE || state == ST_LOCKED)) begin
            status_nxt = accept;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (|(status_nxt & ZERO_MASK)) begin
                    state_nxt = ST_ZEROIZE;
                end else if (|status_nxt) begin
                    state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (|(accept & ZERO_MASK)) begin
                    state_nxt = ST_ZEROIZE;
                end else if (CLEAR && !any_accept) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ZEROIZE: begin
                if (hold_tmr == '0) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Responses are decoded from the next state and status so they move with STATUS.
    always_comb begin
        lock_n_d = TAMPER_INACTIVE_N;
        io_n_d   = TAMPER_INACTIVE_N;
        zero_n_d = TAMPER_INACTIVE_N;
        case (state_nxt)
            ST_LOCKED: begin
                lock_n_d = ~|(status_nxt & LOCK_MASK);
                io_n_d   = ~|(status_nxt & IO_MASK);
            end
            ST_ZEROIZE: begin
                lock_n_d = 1'b0;
                io_n_d   = 1'b0;
                zero_n_d = 1'b0;
            end
            ST_HALT: begin
                lock_n_d = 1'b0;
                io_n_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lock_n_q <= TAMPER_INACTIVE_N;
            io_n_q   <= TAMPER_INACTIVE_N;
            zero_n_q <= TAMPER_INACTIVE_N;
        end else begin
            lock_n_q <= lock_n_d;
            io_n_q   <= io_n_d;
            zero_n_q <= zero_n_d;
        end
    end

    // Down-counter loaded on ZEROIZE entry; terminal count 0 releases to HALT.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hold_tmr <= '0;
        end else if (state_nxt == ST_ZEROIZE && state != ST_ZEROIZE) begin
            hold_tmr <= HOLD_LOAD;
        end else if (state == ST_ZEROIZE && hold_tmr != '0) begin
            hold_tmr <= hold_tmr - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            status_q   <= '0;
            count_q    <= '0;
            irq_q      <= 1'b0;
            category_q <= '0;
        end else begin
            status_q <= status_nxt;
            irq_q    <= any_accept;
            if (any_accept && count_q != '1) begin
                count_q <= count_q + 1'b1;
            end
            if (TAMPER_CHANGE_STROBE) begin
                category_q <= DETECT_CATEGORY;
            end
        end
    end

    assign LOCKDOWN_ALL_N    = lock_n_q;
    assign DISABLE_ALL_IOS_N = io_n_q;
    assign ZEROIZE_N         = zero_n_q;
    assign STATUS            = status_q;
    assign LAST_CATEGORY     = category_q;
    assign EVENT_COUNT       = count_q;
    assign IRQ               = irq_q;
    assign STATE             = state;

endmodule

// File: tb/tb_tamper_response_ctrl.sv
// Directed table-driven bench for tamper_response_ctrl plus zeroize and reset sequences.
module tb_tamper_response_ctrl;

    localparam int NS = 8;
    localparam int CW = 2;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic [NS-1:0] FLAG_IN, LOCK_MASK, IO_MASK, ZERO_MASK;
    logic [3:0]    DETECT_CATEGORY;
    logic          TAMPER_CHANGE_STROBE, CLEAR;
    logic          LOCKDOWN_ALL_N, DISABLE_ALL_IOS_N, ZEROIZE_N, IRQ;
    logic [NS-1:0] STATUS;
    logic [3:0]    LAST_CATEGORY;
    logic [CW-1:0] EVENT_COUNT;
    logic [1:0]    STATE;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    tamper_response_ctrl #(
        .NUM_SRC(NS), .DEBOUNCE(4), .CNT_W(CW), .ZEROIZE_HOLD(16)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .FLAG_IN(FLAG_IN), .LOCK_MASK(LOCK_MASK),
        .IO_MASK(IO_MASK), .ZERO_MASK(ZERO_MASK), .DETECT_CATEGORY(DETECT_CATEGORY),
        .TAMPER_CHANGE_STROBE(TAMPER_CHANGE_STROBE), .CLEAR(CLEAR),
        .LOCKDOWN_ALL_N(LOCKDOWN_ALL_N), .DISABLE_ALL_IOS_N(DISABLE_ALL_IOS_N),
        .ZEROIZE_N(ZEROIZE_N), .STATUS(STATUS), .LAST_CATEGORY(LAST_CATEGORY),
        .EVENT_COUNT(EVENT_COUNT), .IRQ(IRQ), .STATE(STATE)
    );

    typedef struct {
        logic [7:0] flag, lm, im, zm;
        logic [3:0] cat;
        logic       stb, clr;
        logic [7:0] e_status;
        logic [1:0] e_state;
        logic       e_lock, e_io, e_zero, e_irq;
        logic [1:0] e_cnt;
        logic [3:0] e_cat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] flag, lm, im, zm, input logic [3:0] cat,
                                input logic stb, clr, input logic [7:0] st, input logic [1:0] state,
                                input logic lk, io, z, irq, input logic [1:0] cnt, input logic [3:0] ecat);
        vec_t v;
        v.flag = flag; v.lm = lm; v.im = im; v.zm = zm; v.cat = cat; v.stb = stb; v.clr = clr;
        v.e_status = st; v.e_state = state; v.e_lock = lk; v.e_io = io; v.e_zero = z;
        v.e_irq = irq; v.e_cnt = cnt; v.e_cat = ecat;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_idle();
        FLAG_IN = '0; LOCK_MASK = '0; IO_MASK = '0; ZERO_MASK = '0;
        DETECT_CATEGORY = '0; TAMPER_CHANGE_STROBE = 1'b0; CLEAR = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
    endtask

    task automatic chk_reset_values(input int idx);
        chk("rst_state", idx, 32'(STATE), 0);
        chk("rst_status", idx, 32'(STATUS), 0);
        chk("rst_count", idx, 32'(EVENT_COUNT), 0);
        chk("rst_cat", idx, 32'(LAST_CATEGORY), 0);
        chk("rst_irq", idx, 32'(IRQ), 0);
        chk("rst_lock_n", idx, 32'(LOCKDOWN_ALL_N), 1);
        chk("rst_io_n", idx, 32'(DISABLE_ALL_IOS_N), 1);
        chk("rst_zero_n", idx, 32'(ZEROIZE_N), 1);
    endtask

    initial begin
        int zcycles;

        // flag / lm / im / zm / cat / stb / clr || status / state / lock / io / zero / irq / cnt / cat
        // short debounce pulse: never accepted
        vecs.push_back(mk(8'h04,8'h04,0,0,0,0,0, 8'h00,0,1,1,1,0,0,0));
        vecs.push_back(mk(8'h04,8'h04,0,0,0,0,0, 8'h00,0,1,1,1,0,0,0));
        vecs.push_back(mk(8'h04,8'h04,0,0,0,0,0, 8'h00,0,1,1,1,0,0,0));
        vecs.push_back(mk(8'h00,8'h04,0,0,0,0,0, 8'h00,0,1,1,1,0,0,0));
        // long pulse on source 2: accepted on 4th sample, lockdown only
        vecs.push_back(mk(8'h04,8'h04,0,0,0,0,0, 8'h00,0,1,1,1,0,0,0));
        vecs.push_back(mk(8'h04,8'h04,0,0,0,0,0, 8'h00,0,1,1,1,0,0,0));
        vecs.push_back(mk(8'h04,8'h04,0,0,0,0,0, 8'h00,0,1,1,1,0,0,0));
        vecs.push_back(mk(8'h04,8'h04,0,0,0,0,0, 8'h04,1,0,1,1,1,1,0));
        vecs.push_back(mk(8'h04,8'h04,0,0,0,0,0, 8'h04,1,0,1,1,0,1,0));
        vecs.push_back(mk(8'h04,8'h04,0,0,0,0,0, 8'h04,1,0,1,1,0,1,0));
        vecs.push_back(mk(8'h00,8'h04,0,0,0,0,0, 8'h04,1,0,1,1,0,1,0));
        vecs.push_back(mk(8'h00,8'h04,0,0,0,0,1, 8'h00,0,1,1,1,0,1,0));
        // category capture only on strobe
        vecs.push_back(mk(8'h00,8'h04,0,0,4'hA,1,0, 8'h00,0,1,1,1,0,1,4'hA));
        vecs.push_back(mk(8'h04,8'h04,0,0,4'h5,0,0, 8'h00,0,1,1,1,0,1,4'hA));
        vecs.push_back(mk(8'h04,8'h04,0,0,0,0,0, 8'h00,0,1,1,1,0,1,4'hA));
        vecs.push_back(mk(8'h04,8'h04,0,0,0,0,0, 8'h00,0,1,1,1,0,1,4'hA));
        vecs.push_back(mk(8'h04,8'h04,0,0,0,0,0, 8'h04,1,0,1,1,1,2,4'hA));
        // source 5 accepted together with CLEAR: new bit wins, old bit cleared
        vecs.push_back(mk(8'h20,8'h04,0,0,0,0,0, 8'h04,1,0,1,1,0,2,4'hA));
        vecs.push_back(mk(8'h20,8'h04,0,0,0,0,0, 8'h04,1,0,1,1,0,2,4'hA));
        vecs.push_back(mk(8'h20,8'h04,0,0,0,0,0, 8'h04,1,0,1,1,0,2,4'hA));
        vecs.push_back(mk(8'h20,8'h04,0,0,0,0,1, 8'h20,1,1,1,1,1,3,4'hA));
        // mask change while LOCKED takes effect on the next edge
        vecs.push_back(mk(8'h00,8'h20,8'h20,0,0,0,0, 8'h20,1,0,0,1,0,3,4'hA));
        vecs.push_back(mk(8'h00,8'h20,8'h20,0,0,0,1, 8'h00,0,1,1,1,0,3,4'hA));
        // events 4 and 5: counter saturated at 3
        vecs.push_back(mk(8'h08,8'h20,8'h20,0,0,0,0, 8'h00,0,1,1,1,0,3,4'hA));
        vecs.push_back(mk(8'h08,8'h20,8'h20,0,0,0,0, 8'h00,0,1,1,1,0,3,4'hA));
        vecs.push_back(mk(8'h08,8'h20,8'h20,0,0,0,0, 8'h00,0,1,1,1,0,3,4'hA));
        vecs.push_back(mk(8'h08,8'h20,8'h20,0,0,0,0, 8'h08,1,1,1,1,1,3,4'hA));
        vecs.push_back(mk(8'h00,8'h20,8'h20,0,0,0,1, 8'h00,0,1,1,1,0,3,4'hA));
        vecs.push_back(mk(8'h10,8'h20,8'h20,0,0,0,0, 8'h00,0,1,1,1,0,3,4'hA));
        vecs.push_back(mk(8'h10,8'h20,8'h20,0,0,0,0, 8'h00,0,1,1,1,0,3,4'hA));
        vecs.push_back(mk(8'h10,8'h20,8'h20,0,0,0,0, 8'h00,0,1,1,1,0,3,4'hA));
        vecs.push_back(mk(8'h10,8'h20,8'h20,0,0,0,0, 8'h10,1,1,1,1,1,3,4'hA));
        vecs.push_back(mk(8'h00,8'h20,8'h20,0,0,0,1, 8'h00,0,1,1,1,0,3,4'hA));

        do_reset();
        chk_reset_values(-1);

        foreach (vecs[i]) begin
            FLAG_IN = vecs[i].flag; LOCK_MASK = vecs[i].lm; IO_MASK = vecs[i].im;
            ZERO_MASK = vecs[i].zm; DETECT_CATEGORY = vecs[i].cat;
            TAMPER_CHANGE_STROBE = vecs[i].stb; CLEAR = vecs[i].clr;
            cyc();
            chk("status", i, 32'(STATUS), 32'(vecs[i].e_status));
            chk("state", i, 32'(STATE), 32'(vecs[i].e_state));
            chk("lock_n", i, 32'(LOCKDOWN_ALL_N), 32'(vecs[i].e_lock));
            chk("io_n", i, 32'(DISABLE_ALL_IOS_N), 32'(vecs[i].e_io));
            chk("zero_n", i, 32'(ZEROIZE_N), 32'(vecs[i].e_zero));
            chk("irq", i, 32'(IRQ), 32'(vecs[i].e_irq));
            chk("count", i, 32'(EVENT_COUNT), 32'(vecs[i].e_cnt));
            chk("last_cat", i, 32'(LAST_CATEGORY), 32'(vecs[i].e_cat));
        end

        // Simultaneous acceptance of sources 0 and 1 with source 0 zero-masked.
        do_reset();
        ZERO_MASK = 8'h01;
        FLAG_IN   = 8'h03;
        repeat (4) cyc();
        chk("zz_status", 100, 32'(STATUS), 32'h03);
        chk("zz_state", 100, 32'(STATE), 2);
        chk("zz_count", 100, 32'(EVENT_COUNT), 1);
        chk("zz_irq", 100, 32'(IRQ), 1);
        chk("zz_lock_n", 100, 32'(LOCKDOWN_ALL_N), 0);
        chk("zz_io_n", 100, 32'(DISABLE_ALL_IOS_N), 0);
        chk("zz_zero_n", 100, 32'(ZEROIZE_N), 0);
        FLAG_IN = '0;
        zcycles = 1;
        for (int i = 0; i < 40; i++) begin
            CLEAR = (i == 4);
            cyc();
            CLEAR = 1'b0;
            if (ZEROIZE_N !== 1'b0) break;
            zcycles++;
        end
        chk("zz_low_cycles", 101, 32'(zcycles), 16);
        chk("halt_state", 101, 32'(STATE), 3);
        chk("halt_lock_n", 101, 32'(LOCKDOWN_ALL_N), 0);
        chk("halt_io_n", 101, 32'(DISABLE_ALL_IOS_N), 0);
        chk("halt_status", 101, 32'(STATUS), 32'h03);
        CLEAR = 1'b1;
        cyc();
        CLEAR = 1'b0;
        cyc();
        chk("halt_clr_state", 102, 32'(STATE), 3);
        chk("halt_clr_status", 102, 32'(STATUS), 32'h03);
        chk("halt_clr_lock_n", 102, 32'(LOCKDOWN_ALL_N), 0);
        chk("halt_clr_zero_n", 102, 32'(ZEROIZE_N), 1);
        chk("halt_clr_count", 102, 32'(EVENT_COUNT), 1);

        // Asynchronous reset in the middle of ZEROIZE.
        do_reset();
        ZERO_MASK = 8'h01;
        FLAG_IN   = 8'h01;
        DETECT_CATEGORY = 4'hC;
        TAMPER_CHANGE_STROBE = 1'b1;
        cyc();
        TAMPER_CHANGE_STROBE = 1'b0;
        repeat (3) cyc();
        chk("pre_rst_state", 103, 32'(STATE), 2);
        chk("pre_rst_cat", 103, 32'(LAST_CATEGORY), 32'hC);
        repeat (5) cyc();
        #2;
        RESET_N = 1'b0;
        #1;
        chk_reset_values(104);
        FLAG_IN = '0;
        @(negedge CLK);
        RESET_N = 1'b1;
        cyc();
        chk("post_rst_state", 105, 32'(STATE), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tamper_response_ctrl.md
# tamper_response_ctrl

Parametrised tamper monitor and response sequencer. It sits beside the device TAMPER macro wrapper and consumes its detect flags plus any fabric-level tamper sources. Each source is debounced and latched as sticky status, and the controller drives the macro's LOCKDOWN_ALL_N, DISABLE_ALL_IOS_N and ZEROIZE_N inputs under per-source response masks, replacing the tie-to-VCC arrangement. It also keeps a saturating event count, the last captured detect category and an interrupt pulse for the system controller.

## Interface
- NUM_SRC, 8: number of tamper flag inputs (1..32)
- DEBOUNCE, 4: consecutive high samples required to accept a flag (>=1)
- CNT_W, 8: event counter width
- ZEROIZE_HOLD, 16: cycles ZEROIZE_N is held low (>=1)

Ports (clock and reset first):
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- FLAG_IN  in  NUM_SRC  raw tamper flags, active-high, already synchronous to CLK
- LOCK_MASK  in  NUM_SRC  sources that trigger lockdown
- IO_MASK  in  NUM_SRC  sources that trigger I/O disable
- ZERO_MASK  in  NUM_SRC  sources that trigger zeroization
- DETECT_CATEGORY  in  4  category from the TAMPER macro
- TAMPER_CHANGE_STROBE  in  1  category-valid strobe
- CLEAR  in  1  single-cycle request to clear sticky status
- LOCKDOWN_ALL_N  out  1  to macro, active-low
- DISABLE_ALL_IOS_N  out  1  to macro, active-low
- ZEROIZE_N  out  1  to macro, active-low
- STATUS  out  NUM_SRC  sticky accepted flags
- LAST_CATEGORY  out  4  last strobed category
- EVENT_COUNT  out  CNT_W  saturating acceptance count
- IRQ  out  1  one-cycle pulse on new acceptance
- STATE  out  2  FSM state encoding

## Operation
- **Debounce.** Each source has a counter that increments while FLAG_IN[i]=1 and clears when FLAG_IN[i]=0.
  - A source is accepted on the sample that reaches DEBOUNCE.
  - It is accepted once per assertion; re-acceptance needs FLAG_IN[i] to return to 0 first.
- **Acceptance.** On acceptance STATUS[i] is set. If at least one source is accepted in a cycle:
  - EVENT_COUNT increments by 1, saturating at 2^CNT_W-1.
  - IRQ pulses for one cycle.
- **Category capture.** LAST_CATEGORY loads DETECT_CATEGORY on every TAMPER_CHANGE_STROBE cycle. This is independent of the FSM.
- **FSM states:** IDLE=0, LOCKED=1, ZEROIZE=2, HALT=3.
  - IDLE -> ZEROIZE if (STATUS & ZERO_MASK) != 0 after the update; otherwise IDLE -> LOCKED if STATUS != 0. Zeroize has priority.
  - LOCKED -> ZEROIZE when a zero-masked source is accepted.
  - LOCKED -> IDLE on CLEAR when no source is accepted in that cycle. STATUS clears to 0 in the same cycle.
  - ZEROIZE -> HALT after ZEROIZE_HOLD cycles in ZEROIZE.
  - HALT is left only by RESET_N.
- **Outputs in LOCKED:**
  - LOCKDOWN_ALL_N=0 iff (STATUS & LOCK_MASK) != 0.
  - DISABLE_ALL_IOS_N=0 iff (STATUS & IO_MASK) != 0.
- **Outputs in ZEROIZE and HALT:** LOCKDOWN_ALL_N=0 and DISABLE_ALL_IOS_N=0 regardless of masks.
  - ZEROIZE_N=0 only in ZEROIZE.
- **CLEAR rules:**
  - Ignored in ZEROIZE and HALT.
  - If a source is accepted in the same cycle as CLEAR, the acceptance wins: the new bit is set, old bits clear, and the state remains or becomes LOCKED.
  - EVENT_COUNT is never cleared by CLEAR.
- **Masks** are sampled every cycle. Changing a mask while LOCKED updates the lock and I/O outputs on the next edge.

## Timing
- **Reset values:**
  - STATE=IDLE; STATUS=0; EVENT_COUNT=0; LAST_CATEGORY=0; IRQ=0.
  - LOCKDOWN_ALL_N, DISABLE_ALL_IOS_N and ZEROIZE_N are all 1.
  - Debounce counters are 0.
- **Acceptance latency:** FLAG_IN high from edge k; STATUS, IRQ and the EVENT_COUNT update are visible after edge k+DEBOUNCE-1.
- **Response latency:** LOCKDOWN_ALL_N, DISABLE_ALL_IOS_N and ZEROIZE_N are registered from the next state and status. They change on the same edge as STATUS. All outputs are registered, with no combinational path from inputs.
- **Zeroize duration:** ZEROIZE_N is low for exactly ZEROIZE_HOLD cycles.
- **Asynchronous reset:** RESET_N low at any time, including mid-ZEROIZE, forces all reset values immediately. Deassertion is assumed synchronised upstream.

## Structure
- Package tamper_pkg:
  - State enum tamper_state_t with the encodings above.
  - Output inactive constant TAMPER_INACTIVE_N=1'b1.
- Sub-module tamper_debounce: one instance per source.
  - Ports: CLK, RESET_N, FLAG_IN, ACCEPT pulse.
  - Parameter: DEBOUNCE.
- FSM, counters and masks live in the top module.

## Test plan
- DEBOUNCE=4, FLAG_IN[2] high for 3 cycles then low -> STATUS=0, IRQ never asserted, EVENT_COUNT=0.
- FLAG_IN[2] high for 6 cycles, LOCK_MASK=0x04, IO_MASK=0 -> STATUS=0x04 at cycle 4, IRQ one pulse, EVENT_COUNT=1, LOCKDOWN_ALL_N=0, DISABLE_ALL_IOS_N=1, STATE=LOCKED. FLAG_IN low then CLEAR -> STATE=IDLE, STATUS=0, EVENT_COUNT still 1.
- ZERO_MASK=0x01 with flags 0 and 1 accepted in the same cycle -> EVENT_COUNT+1 (not +2), STATE=ZEROIZE, ZEROIZE_N low for 16 cycles, then HALT with lock and I/O outputs low. CLEAR in HALT -> no change.
- CLEAR coincident with acceptance of flag 5 while LOCKED with STATUS=0x04 -> STATUS=0x20, STATE=LOCKED.
- CNT_W=2 with five separate accepted events -> EVENT_COUNT stops at 3. TAMPER_CHANGE_STROBE with DETECT_CATEGORY=0xA -> LAST_CATEGORY=0xA.
- RESET_N asserted mid-ZEROIZE -> all outputs take reset values immediately.
